// File: rtl/ws_write_s_pkg.sv
// Shared types and constants for the write-S stage: FSM states, plane select,
// plane bases, row pitches and block-grid limits.
package ws_write_s_pkg;

  typedef enum logic [2:0] {
    S_WS_IDLE,
    S_WS_LI,
    S_WS_CC,
    S_WS_LO_1,
    S_WS_LO_2,
    S_WS_DONE
  } WS_state_type;

  typedef enum logic [1:0] {
    PLANE_Y,
    PLANE_U,
    PLANE_V
  } plane_t;

  localparam logic [6:0]  DP_BASE_DEF = 7'd0;
  localparam logic [17:0] Y_BASE_DEF  = 18'd0;
  localparam logic [17:0] U_BASE_DEF  = 18'd38400;
  localparam logic [17:0] V_BASE_DEF  = 18'd57600;

  localparam int ROW_PITCH_Y  = 160;
  localparam int ROW_PITCH_UV = 80;

  localparam logic [5:0] C_END_Y  = 6'd39;
  localparam logic [5:0] C_END_UV = 6'd19;
  localparam logic [4:0] RB_END   = 5'd29;

endpackage

// File: rtl/ws_write_s_if.sv
// Handshake, DPRAM-read and SRAM-write signals of the write-S stage.
// master = M2 controller / memories side, slave = the write-S stage.
interface ws_write_s_if;

  logic        WS_start;
  logic        WS_done;
  logic        WS_frame_done;
  logic [6:0]  WS_read_address;
  logic [31:0] WS_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    output WS_start, WS_read_data,
    input  WS_done, WS_frame_done, WS_read_address,
    input  SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    input  WS_start, WS_read_data,
    output WS_done, WS_frame_done, WS_read_address,
    output SRAM_address, SRAM_write_data, SRAM_we_n
  );

endinterface

// File: rtl/ws_sram_addr_gen.sv
// Combinational SRAM word address for write j of the current block.
// Row pitch multiplies are shift-add only: 160 = 128+32, 80 = 64+16.
module ws_sram_addr_gen
  import ws_write_s_pkg::*;
#(
  parameter logic [17:0] Y_BASE = Y_BASE_DEF,
  parameter logic [17:0] U_BASE = U_BASE_DEF,
  parameter logic [17:0] V_BASE = V_BASE_DEF
) (
  input  plane_t      plane,
  input  logic [4:0]  rb,
  input  logic [5:0]  cb,
  input  logic [4:0]  j,
  output logic [17:0] addr
);

  logic [7:0]  row;
  logic [7:0]  col;
  logic [17:0] row_w;
  logic [17:0] col_w;

  assign row   = {rb, 3'b000} + {5'd0, j[4:2]};
  assign col   = {cb, 2'b00} + {6'd0, j[1:0]};
  assign row_w = {10'd0, row};
  assign col_w = {10'd0, col};

  always_comb begin
    addr = Y_BASE;
    unique case (plane)
      PLANE_Y: addr = Y_BASE + (row_w << 7) + (row_w << 5) + col_w;
      PLANE_U: addr = U_BASE + (row_w << 6) + (row_w << 4) + col_w;
      PLANE_V: addr = V_BASE + (row_w << 6) + (row_w << 4) + col_w;
      default: addr = Y_BASE;
    endcase
  end

endmodule

// File: rtl/ws_write_s.sv
// Write-S stage: reads one 8x8 S block from DPRAM, clips to 8 bits, writes 32 pixel pairs to SRAM.
// Block takes 68 cycles start-to-idle (WS_done at T+67); WS_start outside IDLE is ignored.
module ws_write_s
  import ws_write_s_pkg::*;
#(
  parameter logic [6:0]  DP_BASE   = DP_BASE_DEF,
  parameter logic [17:0] Y_BASE    = Y_BASE_DEF,
  parameter logic [17:0] U_BASE    = U_BASE_DEF,
  parameter logic [17:0] V_BASE    = V_BASE_DEF,
  parameter logic [4:0]  RB_LAST   = RB_END,
  parameter logic [5:0]  C_LAST_Y  = C_END_Y,
  parameter logic [5:0]  C_LAST_UV = C_END_UV
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  ws_write_s_if.slave ws
);

  WS_state_type state, next_state;

  logic [5:0]  rd_k;
  logic        rd_vld;
  logic [5:0]  d_k;
  logic [7:0]  even_pix;
  logic [7:0]  pix;
  logic [4:0]  rb;
  logic [5:0]  cb;
  logic [5:0]  c_end;
  plane_t      plane;
  logic [17:0] wr_addr;

  logic        sram_we_n;
  logic [17:0] sram_address;
  logic [15:0] sram_write_data;
  logic        done;
  logic        frame_done;

  ws_sram_addr_gen #(
    .Y_BASE (Y_BASE),
    .U_BASE (U_BASE),
    .V_BASE (V_BASE)
  ) u_addr_gen (
    .plane (plane),
    .rb    (rb),
    .cb    (cb),
    .j     (d_k[5:1]),
    .addr  (wr_addr)
  );

  // Negative values floor at 0, anything above 255 saturates.
  always_comb begin
    pix = ws.WS_read_data[7:0];
    if (ws.WS_read_data[31])
      pix = 8'd0;
    else if (|ws.WS_read_data[30:8])
      pix = 8'd255;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn)
      state <= S_WS_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_WS_IDLE: if (ws.WS_start) next_state = S_WS_LI;
      S_WS_LI:   next_state = S_WS_CC;
      S_WS_CC:   if (rd_k == 6'd63) next_state = S_WS_LO_1;
      S_WS_LO_1: next_state = S_WS_LO_2;
      S_WS_LO_2: next_state = S_WS_DONE;
      S_WS_DONE: next_state = S_WS_IDLE;
      default:   next_state = S_WS_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (!Resetn) begin
      rd_k            <= 6'd0;
      rd_vld          <= 1'b0;
      d_k             <= 6'd0;
      even_pix        <= 8'd0;
      sram_we_n       <= 1'b1;
      sram_address    <= 18'd0;
      sram_write_data <= 16'd0;
      done            <= 1'b0;
      frame_done      <= 1'b0;
      rb              <= 5'd0;
      cb              <= 6'd0;
      c_end           <= C_LAST_Y;
      plane           <= PLANE_Y;
    end else begin
      sram_we_n  <= 1'b1;
      done       <= 1'b0;
      frame_done <= 1'b0;
      rd_vld     <= (state == S_WS_LI) || (state == S_WS_CC);

      if (state == S_WS_IDLE && ws.WS_start) begin
        rd_k <= 6'd0;
        d_k  <= 6'd0;
      end else if (state == S_WS_LI || state == S_WS_CC) begin
        rd_k <= rd_k + 6'd1;
      end

      // Data arrives one cycle after its address; odd samples complete a pair.
      if (rd_vld) begin
        d_k <= d_k + 6'd1;
        if (!d_k[0]) begin
          even_pix <= pix;
        end else begin
          sram_we_n       <= 1'b0;
          sram_address    <= wr_addr;
          sram_write_data <= {even_pix, pix};
        end
      end

      if (state == S_WS_LO_2) begin
        done       <= 1'b1;
        frame_done <= (plane == PLANE_V) && (rb == RB_LAST) && (cb == c_end);
      end

      if (state == S_WS_DONE) begin
        if (cb == c_end) begin
          cb <= 6'd0;
          if (rb == RB_LAST) begin
            rb <= 5'd0;
            unique case (plane)
              PLANE_Y: begin plane <= PLANE_U; c_end <= C_LAST_UV; end
              PLANE_U: begin plane <= PLANE_V; c_end <= C_LAST_UV; end
              default: begin plane <= PLANE_Y; c_end <= C_LAST_Y;  end
            endcase
          end else begin
            rb <= rb + 5'd1;
          end
        end else begin
          cb <= cb + 6'd1;
        end
      end
    end
  end

  assign ws.WS_read_address = DP_BASE + {1'b0, rd_k};
  assign ws.SRAM_we_n       = sram_we_n;
  assign ws.SRAM_address    = sram_address;
  assign ws.SRAM_write_data = sram_write_data;
  assign ws.WS_done         = done;
  assign ws.WS_frame_done   = frame_done;

endmodule

// File: tb/tb_ws_write_s.sv
// Bench for ws_write_s: full-size instance plus a shrunken-grid instance (3x4 Y, 3x2 U/V blocks)
// so plane changes and frame wrap are reached quickly; both share stimulus and DPRAM contents.
module tb_ws_write_s;

  logic clk = 1'b0;
  logic rstn;
  logic start;

  ws_write_s_if ifa ();
  ws_write_s_if ifb ();

  ws_write_s dut_a (
    .CLOCK_50_I (clk),
    .Resetn     (rstn),
    .ws         (ifa)
  );

  ws_write_s #(
    .RB_LAST   (5'd2),
    .C_LAST_Y  (6'd3),
    .C_LAST_UV (6'd1)
  ) dut_b (
    .CLOCK_50_I (clk),
    .Resetn     (rstn),
    .ws         (ifb)
  );

  always #5 clk = ~clk;

  assign ifa.WS_start = start;
  assign ifb.WS_start = start;

  logic [31:0] mem [0:127];

  always @(posedge clk) begin
    ifa.WS_read_data <= mem[ifa.WS_read_address];
    ifb.WS_read_data <= mem[ifb.WS_read_address];
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Block-level model: when a block was accepted and which block of the frame it is.
  int cyc      = 0;
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_blk    = 0;
  int m_cur    = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_active = 1'b0;
      m_blk    = 0;
      chk_en   = 1'b1;
    end else if (start && (!m_active || (cyc - m_t) >= 68)) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_cur    = m_blk;
      m_blk++;
    end
    cyc++;
  end

  function automatic int model_addr(int rbe, int cy, int cuv, int blk, int j);
    int ny, nu, n, base, pitch, cols, m;
    ny = (rbe + 1) * (cy + 1);
    nu = (rbe + 1) * (cuv + 1);
    n  = blk % (ny + 2 * nu);
    if (n < ny) begin
      base = 0;     pitch = 160; cols = cy + 1;  m = n;
    end else if (n < ny + nu) begin
      base = 38400; pitch = 80;  cols = cuv + 1; m = n - ny;
    end else begin
      base = 57600; pitch = 80;  cols = cuv + 1; m = n - ny - nu;
    end
    return base + (8 * (m / cols) + j / 4) * pitch + 4 * (m % cols) + j % 4;
  endfunction

  function automatic bit model_last(int rbe, int cy, int cuv, int blk);
    int total;
    total = (rbe + 1) * (cy + 1) + 2 * (rbe + 1) * (cuv + 1);
    return (blk % total) == total - 1;
  endfunction

  function automatic logic [7:0] clip(logic [31:0] v);
    if ($signed(v) < 0) return 8'd0;
    if ($signed(v) > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic chk_inst(input string tag, input int rbe, input int cy, input int cuv,
                          input logic we_n, input logic dn, input logic fd,
                          input logic [17:0] addr, input logic [15:0] wd, input logic [6:0] ra);
    int d, j;
    bit exp_wr, exp_done;
    d        = cyc - m_t;
    exp_wr   = m_active && d >= 4 && d <= 66 && (d % 2) == 0;
    exp_done = m_active && d == 67;
    check({tag, "_we_n"}, 32'(we_n), 32'(!exp_wr));
    check({tag, "_done"}, 32'(dn), 32'(exp_done));
    check({tag, "_frame_done"}, 32'(fd), 32'(exp_done && model_last(rbe, cy, cuv, m_cur)));
    if (exp_wr) begin
      j = (d - 4) / 2;
      check({tag, "_addr"}, 32'(addr), 32'(model_addr(rbe, cy, cuv, m_cur, j)));
      check({tag, "_data"}, 32'(wd), {16'd0, clip(mem[2 * j]), clip(mem[2 * j + 1])});
    end
    if (m_active && d >= 1 && d <= 64)
      check({tag, "_rd_addr"}, 32'(ra), 32'(d - 1));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_inst("a", 29, 39, 19, ifa.SRAM_we_n, ifa.WS_done, ifa.WS_frame_done,
               ifa.SRAM_address, ifa.SRAM_write_data, ifa.WS_read_address);
      chk_inst("b", 2, 3, 1, ifb.SRAM_we_n, ifb.WS_done, ifb.WS_frame_done,
               ifb.SRAM_address, ifb.SRAM_write_data, ifb.WS_read_address);
    end
  end

  // Per-block capture for the literal expectations.
  int qa_addr [$];
  int qa_dat  [$];
  int qa_cyc  [$];
  int qb_addr [$];
  int a_wr_cnt = 0;
  int a_done_cnt = 0;
  int a_done_cyc = 0;
  bit b_frame = 1'b0;

  always @(negedge clk) begin
    if (ifa.SRAM_we_n === 1'b0) begin
      qa_addr.push_back(int'(ifa.SRAM_address));
      qa_dat.push_back(int'(ifa.SRAM_write_data));
      qa_cyc.push_back(cyc);
      a_wr_cnt++;
    end
    if (ifa.WS_done === 1'b1) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    if (ifb.SRAM_we_n === 1'b0) qb_addr.push_back(int'(ifb.SRAM_address));
    if (ifb.WS_done === 1'b1) b_frame = ifb.WS_frame_done;
  end

  task automatic run_block(input int repulse_at, output int t_start);
    bit seen;
    qa_addr.delete();
    qa_dat.delete();
    qa_cyc.delete();
    qb_addr.delete();
    b_frame = 1'b0;
    t_start = cyc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge clk);
      start = (i == repulse_at);
      if (ifa.WS_done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    int v;
    for (int k = 0; k < 64; k++) begin
      v = int'($urandom_range(0, 700)) - 200;
      mem[k] = v;
    end
    mem[5] = 32'h7FFF_0000;
    mem[6] = 32'h8000_0001;
  endtask

  initial begin
    int ts;
    rstn  = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 128; k++) mem[k] = k;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we_n", 32'(ifa.SRAM_we_n), 32'd1);
    check("rst_done", 32'(ifa.WS_done), 32'd0);
    check("rst_addr", 32'(ifa.SRAM_address), 32'd0);
    check("rst_wdata", 32'(ifa.SRAM_write_data), 32'd0);
    check("rst_rd_addr", 32'(ifa.WS_read_address), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // First Y block, DPRAM[k]=k
    run_block(-1, ts);
    check("b0_nwr", 32'(qa_addr.size()), 32'd32);
    check("b0_addr0", 32'(qa_addr[0]), 32'd0);
    check("b0_addr3", 32'(qa_addr[3]), 32'd3);
    check("b0_addr4", 32'(qa_addr[4]), 32'd160);
    check("b0_addr31", 32'(qa_addr[31]), 32'd1123);
    check("b0_dat0", 32'(qa_dat[0]), 32'h0001);
    check("b0_dat1", 32'(qa_dat[1]), 32'h0203);
    check("b0_dat31", 32'(qa_dat[31]), 32'h3E3F);
    check("b0_first_wr_t", 32'(qa_cyc[0] - ts), 32'd4);
    check("b0_last_wr_t", 32'(qa_cyc[31] - ts), 32'd66);
    check("b0_done_t", 32'(a_done_cyc - ts), 32'd67);

    // Clipping
    mem[0] = 32'hFFFF_FFFB;
    mem[1] = 32'd300;
    mem[2] = 32'd255;
    mem[3] = 32'd256;
    run_block(-1, ts);
    check("clip_addr0", 32'(qa_addr[0]), 32'd4);
    check("clip_w0", 32'(qa_dat[0]), 32'h00FF);
    check("clip_w1", 32'(qa_dat[1]), 32'hFFFF);

    // WS_start held high for 200 cycles: blocks accepted at +0, +68, +136
    a_wr_cnt = 0;
    a_done_cnt = 0;
    start = 1'b1;
    repeat (200) @(posedge clk);
    #1 start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("hold_writes", 32'(a_wr_cnt), 32'd96);
    check("hold_dones", 32'(a_done_cnt), 32'd3);

    // Re-pulse mid-block is ignored
    a_wr_cnt = 0;
    a_done_cnt = 0;
    run_block(30, ts);
    repeat (10) @(posedge clk);
    #1;
    check("repulse_writes", 32'(a_wr_cnt), 32'd32);
    check("repulse_dones", 32'(a_done_cnt), 32'd1);

    // Reset mid-block
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mrst_we_n", 32'(ifa.SRAM_we_n), 32'd1);
    check("mrst_done", 32'(ifa.WS_done), 32'd0);
    check("mrst_frame", 32'(ifa.WS_frame_done), 32'd0);
    check("mrst_addr", 32'(ifa.SRAM_address), 32'd0);
    rstn = 1'b1;
    a_wr_cnt = 0;
    repeat (60) @(posedge clk);
    #1;
    check("mrst_no_writes", 32'(a_wr_cnt), 32'd0);

    for (int i = 0; i < 42; i++) begin
      if (i > 0) fill_random();
      run_block(-1, ts);
      if (i == 0) begin
        check("post_rst_a_addr0", 32'(qa_addr[0]), 32'd0);
        check("post_rst_b_addr0", 32'(qb_addr[0]), 32'd0);
      end
      if (i == 12) check("b_u_start", 32'(qb_addr[0]), 32'd38400);
      if (i == 18) check("b_v_start", 32'(qb_addr[0]), 32'd57600);
      if (i == 23) begin
        check("b_frame_last_addr", 32'(qb_addr[31]), 32'd59447);
        check("b_frame_done", 32'(b_frame), 32'd1);
      end
      if (i == 24) check("b_wrap_addr0", 32'(qb_addr[0]), 32'd0);
      if (i == 41) begin
        check("a_blk42_first", 32'(qa_addr[0]), 32'd1284);
        check("a_blk42_last", 32'(qa_addr[31]), 32'd2407);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
